// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the UART-style serial frame receiver.
package serial_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Clock divider and bit counter: pulses sample_strobe at the middle of each serial bit
// and counts samples taken since the last restart (0 = start bit).
module rx_bit_timer
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  localparam int TW          = $clog2(CLKS_PER_BIT),
  localparam int BW          = $clog2(DATA_BITS + 2)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable,
  input  logic          restart,
  output logic          sample_strobe,
  output logic [BW-1:0] bit_idx
);

  // Restart happens on the edge-detect cycle, so the first sample needs HALF-1 ticks.
  localparam logic [TW-1:0] FIRST_TICK = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS + 1);

  logic [TW-1:0] timer;
  logic [TW-1:0] threshold;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    threshold     = (bit_idx == '0) ? FIRST_TICK : LAST_TICK;
    sample_strobe = enable && (timer == threshold);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      bit_idx <= '0;
    end else if (restart) begin
      timer   <= '0;
      bit_idx <= '0;
    end else if (enable) begin
      if (sample_strobe) begin
        timer <= '0;
        if (bit_idx != LAST_BIT) bit_idx <= bit_idx + BW'(1);
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_rx_framer.sv
// UART-style frame receiver: start-edge detect, mid-bit sampling, stop-bit check,
// and a ready/read handshake toward the output buffer with overrun/framing flags.
module serial_rx_framer
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int BW = $clog2(DATA_BITS + 2);

  rx_state_t              state;
  logic                   prev_serial;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   start_edge;
  logic                   timer_enable;
  logic                   sample_strobe;
  logic [BW-1:0]          bit_idx;

  assign start_edge   = (state == IDLE) && prev_serial && !serial_in;
  assign timer_enable = (state == START) || (state == DATA) || (state == STOP);

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (timer_enable),
    .restart      (start_edge),
    .sample_strobe(sample_strobe),
    .bit_idx      (bit_idx)
  );

  // NOTE: all state uses non-blocking assignments, so every branch below sees pre-edge values
  // and the LOAD branch can override the handshake clear that precedes it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      prev_serial   <= 1'b1;
      shift_reg     <= '0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      prev_serial <= serial_in;

      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      unique case (state)
        IDLE: if (start_edge) state <= START;
        START: if (sample_strobe) state <= serial_in ? IDLE : DATA;
        DATA: begin
          if (sample_strobe) begin
            shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == BW'(DATA_BITS)) state <= STOP;
          end
        end
        STOP: begin
          if (sample_strobe) begin
            if (serial_in) begin
              state <= LOAD;
            end else begin
              framing_error <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        LOAD: begin
          // A read in this same cycle consumes the old word, so no overrun is flagged.
          rx_data       <= shift_reg;
          data_ready    <= 1'b1;
          framing_error <= 1'b0;
          overrun_error <= data_ready && !data_read;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_framer.sv
// Directed, table-driven bench for serial_rx_framer at default parameters (10 clks/bit, 8 data bits).
module tb_serial_rx_framer;
  import serial_rx_pkg::*;

  localparam int C  = 10;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          serial_in;
  logic          data_read;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;

  int   checks   = 0;
  int   passed   = 0;
  int   cyc      = 0;
  int   rise_cyc = -1;
  logic last_ready = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       glitch;
    logic       read_after;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_ovr;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  serial_rx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_ready && !last_ready && rise_cyc < 0) rise_cyc = cyc;
    last_ready = data_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] d, input logic r,
                               input logic o, input logic f);
    check(name, {21'd0, rx_data, data_ready, overrun_error, framing_error}, {21'd0, d, r, o, f});
  endtask

  // Caller is #1 after a posedge; the start edge is registered at the next posedge (t_edge).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic read_in_load, output int t_edge);
    logic [9:0] bits;
    bits   = {stop_bit, data, 1'b0};
    t_edge = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      serial_in = bits[k];
      for (int c = 0; c < C; c++) begin
        @(posedge clk); #1;
        if (read_in_load && k == 9) data_read = (c == 5);
      end
    end
    serial_in = 1'b1;
    data_read = 1'b0;
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
  endtask

  initial begin
    int t;
    int bad;
    logic [7:0] m_data;
    logic       m_ready, m_ovr, m_fe;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    n_rst = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if ({rx_data, data_ready, overrun_error, framing_error} !== 11'd0) bad++;
    end
    check("idle_200_cycles", bad, 0);
    @(posedge clk); #1;

    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].glitch) begin
        serial_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        serial_in = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check_outputs($sformatf("false_start_quiet_%0d", i), m_data, m_ready, m_ovr, m_fe);
      end
      rise_cyc = -1;
      send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0, t);
      @(negedge clk);
      check_outputs($sformatf("frame_%0d_0x%02h", i, vecs[i].data),
                    vecs[i].exp_data, vecs[i].exp_ready, vecs[i].exp_ovr, vecs[i].exp_fe);
      if (i == 0) check("ready_latency_cycle", rise_cyc, t + 96);
      m_data = vecs[i].exp_data; m_ready = vecs[i].exp_ready;
      m_ovr = vecs[i].exp_ovr;   m_fe = vecs[i].exp_fe;
      @(posedge clk); #1;
      if (vecs[i].read_after) begin
        pulse_read();
        @(negedge clk);
        check_outputs($sformatf("read_clear_%0d", i), m_data, 1'b0, 1'b0, m_fe);
        m_ready = 1'b0; m_ovr = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Read asserted in the LOAD cycle: old word consumed, no overrun, new word pending.
    send_frame(8'h11, 1'b1, 1'b0, t);
    send_frame(8'h22, 1'b1, 1'b1, t);
    @(negedge clk);
    check_outputs("read_in_load", 8'h22, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    pulse_read();

    // Build up non-zero flags, then reset in the middle of data bit 4.
    send_frame(8'h33, 1'b1, 1'b0, t);
    send_frame(8'h44, 1'b1, 1'b0, t);
    send_frame(8'h66, 1'b0, 1'b0, t);
    @(negedge clk);
    check_outputs("pre_reset_flags", 8'h44, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    serial_in = 1'b0;
    repeat (C) begin @(posedge clk); #1; end
    serial_in = 1'b1;
    repeat (4 * C + 3) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    #1;
    check_outputs("mid_frame_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    send_frame(8'h81, 1'b1, 1'b0, t);
    @(negedge clk);
    check_outputs("after_reset_0x81", 8'h81, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
